// File: rtl/apir_simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU with 1/2/4 carry-isolated lanes and valid/ready handshake.
// Optional accumulate mode is enabled by defining APIR_SIMD_ACCUM_EN.
module apir_simd_alu_pipe #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] W,
  input  logic [Width-1:0] X,
  input  logic [Width-1:0] Y,
  input  logic [Width-1:0] Z,
  input  logic [1:0]       op,
  input  logic [1:0]       simd_mode,
  input  logic             Z_controller,
  input  logic             W_X_Y_controller,
  input  logic             S_controller,
  input  logic [3:0]       cin_a,
  input  logic [3:0]       cin_b,
`ifdef APIR_SIMD_ACCUM_EN
  input  logic             accum,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] S,
  output logic [7:0]       lane_cout
);

  localparam int Q = Width / 4;
  localparam int H = 2 * Q;

  localparam logic [1:0] OP_SUM  = 2'b00;
  localparam logic [1:0] OP_XOR3 = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] MODE_2L = 2'b01;
  localparam logic [1:0] MODE_4L = 2'b10;

  // Handshake
  logic w_adv1, w_adv2, w_accept;
  logic r_v1, r_v2;

  assign w_adv2   = !r_v2 | out_ready;
  assign w_adv1   = !r_v1 | w_adv2;
  assign w_accept = in_valid & w_adv1;
  assign in_ready = w_adv1;
  assign out_valid = r_v2;

  // Stage 1 combinational: every lane split is evaluated, mode picks one
  logic [Width+1:0] w_t_full;
  logic [H+1:0]     w_t_half [2];
  logic [Q+1:0]     w_t_quar [4];
  logic [Width-1:0] w_sum1;
  logic [7:0]       w_c1;
  logic [Width-1:0] w_zb;

  assign w_t_full = {2'b00, W} + {2'b00, X} + {2'b00, Y} + {{(Width+1){1'b0}}, cin_a[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_s1_half
      assign w_t_half[gi] = {2'b00, W[gi*H +: H]} + {2'b00, X[gi*H +: H]}
                          + {2'b00, Y[gi*H +: H]} + {{(H+1){1'b0}}, cin_a[gi]};
    end
    for (gi = 0; gi < 4; gi++) begin : g_s1_quar
      assign w_t_quar[gi] = {2'b00, W[gi*Q +: Q]} + {2'b00, X[gi*Q +: Q]}
                          + {2'b00, Y[gi*Q +: Q]} + {{(Q+1){1'b0}}, cin_a[gi]};
    end
  endgenerate

  always_comb begin
    w_sum1 = w_t_full[Width-1:0];
    w_c1   = {6'b000000, w_t_full[Width+1:Width]};
    case (simd_mode)
      MODE_2L: begin
        w_sum1 = {w_t_half[1][H-1:0], w_t_half[0][H-1:0]};
        w_c1   = {4'b0000, w_t_half[1][H+1:H], w_t_half[0][H+1:H]};
      end
      MODE_4L: begin
        w_sum1 = {w_t_quar[3][Q-1:0], w_t_quar[2][Q-1:0],
                  w_t_quar[1][Q-1:0], w_t_quar[0][Q-1:0]};
        w_c1   = {w_t_quar[3][Q+1:Q], w_t_quar[2][Q+1:Q],
                  w_t_quar[1][Q+1:Q], w_t_quar[0][Q+1:Q]};
      end
      default: ;
    endcase
  end

  assign w_zb = Z ^ {Width{Z_controller}};

  // Stage 1 registers
  logic [Width-1:0] r_sum1, r_zb, r_and, r_or, r_xor;
  logic [7:0]       r_c1;
  logic [1:0]       r_op, r_mode;
  logic             r_sc;
  logic [3:0]       r_cin_b;
`ifdef APIR_SIMD_ACCUM_EN
  logic             r_accum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_sum1  <= '0;
      r_zb    <= '0;
      r_and   <= '0;
      r_or    <= '0;
      r_xor   <= '0;
      r_c1    <= '0;
      r_op    <= '0;
      r_mode  <= '0;
      r_sc    <= 1'b0;
      r_cin_b <= '0;
`ifdef APIR_SIMD_ACCUM_EN
      r_accum <= 1'b0;
`endif
    end else begin
      if (w_adv1) begin
        r_v1 <= in_valid;
      end
      if (w_accept) begin
        r_sum1  <= w_sum1 ^ {Width{W_X_Y_controller}};
        r_zb    <= w_zb;
        r_and   <= X & w_zb;
        r_or    <= X | w_zb;
        r_xor   <= X ^ w_zb ^ Y;
        r_c1    <= w_c1;
        r_op    <= op;
        r_mode  <= simd_mode;
        r_sc    <= S_controller;
        r_cin_b <= cin_b;
`ifdef APIR_SIMD_ACCUM_EN
        r_accum <= accum;
`endif
      end
    end
  end

  // Stage 2 combinational
  logic [Width-1:0] w_addend;
  logic [Width:0]   w_u_full;
  logic [H:0]       w_u_half [2];
  logic [Q:0]       w_u_quar [4];
  logic [Width-1:0] w_sum2;
  logic [3:0]       w_c2;
  logic [7:0]       w_cout;
  logic [Width-1:0] w_res;

`ifdef APIR_SIMD_ACCUM_EN
  // Shadow of the last pre-inversion result; feeds back so accumulate beats chain
  logic [Width-1:0] r_raw;
  assign w_addend = r_accum ? r_raw : r_zb;
`else
  assign w_addend = r_zb;
`endif

  assign w_u_full = {1'b0, r_sum1} + {1'b0, w_addend} + {{Width{1'b0}}, r_cin_b[0]};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_s2_half
      assign w_u_half[gi] = {1'b0, r_sum1[gi*H +: H]} + {1'b0, w_addend[gi*H +: H]}
                          + {{H{1'b0}}, r_cin_b[gi]};
    end
    for (gi = 0; gi < 4; gi++) begin : g_s2_quar
      assign w_u_quar[gi] = {1'b0, r_sum1[gi*Q +: Q]} + {1'b0, w_addend[gi*Q +: Q]}
                          + {{Q{1'b0}}, r_cin_b[gi]};
    end
  endgenerate

  always_comb begin
    w_sum2 = w_u_full[Width-1:0];
    w_c2   = {3'b000, w_u_full[Width]};
    case (r_mode)
      MODE_2L: begin
        w_sum2 = {w_u_half[1][H-1:0], w_u_half[0][H-1:0]};
        w_c2   = {2'b00, w_u_half[1][H], w_u_half[0][H]};
      end
      MODE_4L: begin
        w_sum2 = {w_u_quar[3][Q-1:0], w_u_quar[2][Q-1:0],
                  w_u_quar[1][Q-1:0], w_u_quar[0][Q-1:0]};
        w_c2   = {w_u_quar[3][Q], w_u_quar[2][Q], w_u_quar[1][Q], w_u_quar[0][Q]};
      end
      default: ;
    endcase
  end

  // Inactive lanes carry zero c1 and c2, so their count is zero
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cout
      assign w_cout[2*gi +: 2] = r_c1[2*gi +: 2] + {1'b0, w_c2[gi]};
    end
  endgenerate

  always_comb begin
    case (r_op)
      OP_SUM:  w_res = w_sum2;
      OP_XOR3: w_res = r_xor;
      OP_AND:  w_res = r_and;
      default: w_res = r_or;
    endcase
  end

  // Stage 2 registers: data only moves when a valid beat advances
  logic [Width-1:0] r_s;
  logic [7:0]       r_lane_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2        <= 1'b0;
      r_s         <= '0;
      r_lane_cout <= '0;
`ifdef APIR_SIMD_ACCUM_EN
      r_raw       <= '0;
`endif
    end else begin
      if (w_adv2) begin
        r_v2 <= r_v1;
      end
      if (w_adv2 && r_v1) begin
        r_s         <= w_res ^ {Width{r_sc}};
        r_lane_cout <= w_cout;
`ifdef APIR_SIMD_ACCUM_EN
        r_raw       <= w_res;
`endif
      end
    end
  end

  assign S         = r_s;
  assign lane_cout = r_lane_cout;

endmodule

// File: doc/apir_simd_alu_pipe.md
Name: apir_simd_alu_pipe

Overview:
Two-stage pipelined successor to the combinational SIMD ALU in the APIR-DSP datapath.
- Width is parameterised; the lane split is selectable at run time: 1, 2 or 4 lanes.
- Lanes are carry-isolated at their boundaries.
- Valid/ready handshake on input and output, with back-pressure.
- Same arithmetic and logic op set as the previous ALU: W+X+Y, optional inversion, +Z, then XOR3/AND/OR selection and output inversion.

Parameters:
Width, 16, total datapath width; must be a multiple of 4; segment Q = Width/4.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
W, X, Y, Z  in  Width each  operands
op  in  2  00 sum, 01 xor3, 10 and, 11 or
simd_mode  in  2  00 one lane, 01 two lanes, 10 four lanes, 11 reserved (treated as 00)
Z_controller  in  1  invert Z before use
W_X_Y_controller  in  1  invert stage-1 sum
S_controller  in  1  invert final result
cin_a  in  4  per-lane carry into W+X+Y
cin_b  in  4  per-lane carry into +Z
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
S  out  Width  result
lane_cout  out  8  per-lane 2-bit carry count, lane i at [2i+1:2i]

Behaviour:
- Lane map:
  - Mode 00: lane 0 covers [Width-1:0].
  - Mode 01: lane 0 covers [2Q-1:0]; lane 1 covers [Width-1:2Q].
  - Mode 10: lane i covers [(i+1)Q-1:iQ].
  - Unused lanes ignore their cin bits and drive lane_cout = 0.
- Stage 1 (per lane, lane width LW):
  - t = W+X+Y+cin_a[i], computed at LW+2 bits.
  - Register t[LW-1:0] XOR {W_X_Y_controller}, and c1 = t[LW+1:LW].
  - Also register Zb = Z XOR {Z_controller}, the logic results, op, mode, S_controller and cin_b.
  - Logic results: and = X & Zb; or = X | Zb; xor3 = X ^ Zb ^ Y.
- Stage 2 (per lane):
  - u = stage1sum + Zb + cin_b[i], computed at LW+1 bits.
  - c2 = u[LW].
  - lane_cout[i] = c1 + c2, range 0..3, 2 bits. Registered for every op, computed from the sum path.
  - S = mux(op: u, xor3, and, or) XOR {S_controller}, registered.
- Latency: 2 cycles from accept to out_valid when not stalled; throughput 1 beat/cycle.
- Handshake:
  - v1 and v2 are the stage valid bits; out_valid = v2.
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1 (combinational).
  - A beat is accepted on in_valid & in_ready.
  - Stage 2 loads from stage 1 when adv2. Stage 1 loads on acceptance. A stage holds its contents while its advance signal is low.
- Outputs are stable while out_valid & !out_ready.
- Simultaneous accept and drain in the same cycle are allowed with no bubble.
- Reset: v1 = v2 = 0, S = 0, lane_cout = 0, all stage registers 0. Reset mid-operation flushes in-flight beats; no output is produced for them.
- Overflow per lane is dropped and carry does not cross lane boundaries; no saturation.

Optional Feature:
APIR_SIMD_ACCUM_EN
- With the macro: adds input port accum (1 bit, captured with the beat). When a beat has accum=1, stage 2 uses the current S register value in place of Zb for the sum, i.e. u = stage1sum + S_prev + cin_b.
  - S_prev is taken before S_controller inversion; the raw pre-inversion result is kept in a shadow register.
  - Back-to-back accumulate beats chain with no bubble.
  - The shadow register resets to 0.
- Without the macro: no accum port; Zb is always used.

Test Plan:
- Width=16, mode 00, op 00, W=1 X=2 Y=3 Z=4, cins 0, out_ready=1 -> two cycles later out_valid=1, S=16'h000A, lane_cout=0.
- Mode 00, W=16'hFFFF X=1 Y=0 Z=0 -> S=16'h0000, lane_cout[1:0]=01. Same operands in mode 10 -> S=16'hFFF0, lane_cout=8'h01.
- Mode 01, W=X=Y=16'hFFFF, Z=0, cins 0 -> each lane FF+FF+FF=2FD, S=16'hFDFD, lane_cout=8'h0A.
- op 10, X=16'h00FF, Z=16'h0F0F, Z_controller=1, S_controller=1 -> S=16'hFF0F. Same with op 11, S_controller=0 -> S=16'hF0FF.
- out_ready=0, 3 beats offered back-to-back -> first 2 accepted, in_ready=0 from cycle 2 until out_ready rises. Results then emerge in order with none lost or duplicated.
- Assert rst while 2 beats are in flight -> out_valid=0, S=0 immediately; the next beat after release is the first output.
